// File: rtl/countdown_timer.sv
// HH:MM:SS down-counting timer with preset, pause/resume/abort and a held alarm flag.
// Drives six active-low seven-segment digits decoded straight from the live count.
module countdown_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       CLK,
    input  logic       clr_n,
    input  logic       adj_sec,
    input  logic       adj_min,
    input  logic       adj_hou,
    input  logic       start,
    input  logic       pause,
    input  logic       ack,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       running,
    output logic       expired
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [7:0]      r_pre_sec, r_pre_min, r_pre_hou;
    logic [7:0]      r_cnt_sec, r_cnt_min, r_cnt_hou;
    logic            r_running, r_expired;
    logic [5:0]      r_prev;

    // Bit order: {ack, pause, start, adj_hou, adj_min, adj_sec}
    logic [5:0]      w_in, w_edge;
    logic            w_e_sec, w_e_min, w_e_hou, w_e_start, w_e_pause, w_e_ack;
    logic [7:0]      w_pre_sec, w_pre_min, w_pre_hou;
    logic            w_pre_zero;
    logic [7:0]      w_dec_sec, w_dec_min, w_dec_hou;
    logic            w_dec_zero, w_tick;

    assign w_in      = {ack, pause, start, adj_hou, adj_min, adj_sec};
    assign w_edge    = w_in & ~r_prev;
    assign w_e_sec   = w_edge[0];
    assign w_e_min   = w_edge[1];
    assign w_e_hou   = w_edge[2];
    assign w_e_start = w_edge[3];
    assign w_e_pause = w_edge[4];
    assign w_e_ack   = w_edge[5];

    assign w_pre_sec  = w_e_sec ? ((r_pre_sec == 8'd59) ? 8'd0 : r_pre_sec + 8'd1) : r_pre_sec;
    assign w_pre_min  = w_e_min ? ((r_pre_min == 8'd59) ? 8'd0 : r_pre_min + 8'd1) : r_pre_min;
    assign w_pre_hou  = w_e_hou ? ((r_pre_hou == 8'd23) ? 8'd0 : r_pre_hou + 8'd1) : r_pre_hou;
    assign w_pre_zero = ((r_pre_sec | r_pre_min | r_pre_hou) == 8'd0);

    // Borrow chain for one-second decrement; only used while the count is non-zero.
    always_comb begin
        w_dec_sec = r_cnt_sec - 8'd1;
        w_dec_min = r_cnt_min;
        w_dec_hou = r_cnt_hou;
        if (r_cnt_sec == 8'd0) begin
            w_dec_sec = 8'd59;
            if (r_cnt_min != 8'd0) begin
                w_dec_min = r_cnt_min - 8'd1;
            end else begin
                w_dec_min = 8'd59;
                w_dec_hou = r_cnt_hou - 8'd1;
            end
        end
    end

    assign w_dec_zero = ((w_dec_sec | w_dec_min | w_dec_hou) == 8'd0);
    assign w_tick     = (r_presc == TICK_LAST);

    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_pre_sec <= 8'd0;
            r_pre_min <= 8'd0;
            r_pre_hou <= 8'd0;
            r_cnt_sec <= 8'd0;
            r_cnt_min <= 8'd0;
            r_cnt_hou <= 8'd0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_prev    <= '1;
        end else begin
            r_prev <= w_in;
            case (r_state)
                S_IDLE: begin
                    if (w_e_start && !w_pre_zero) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                        r_presc   <= '0;
                    end else begin
                        r_pre_sec <= w_pre_sec;
                        r_pre_min <= w_pre_min;
                        r_pre_hou <= w_pre_hou;
                        r_cnt_sec <= w_pre_sec;
                        r_cnt_min <= w_pre_min;
                        r_cnt_hou <= w_pre_hou;
                    end
                end
                S_RUN: begin
                    r_presc <= w_tick ? '0 : r_presc + PW'(1);
                    if (w_tick) begin
                        r_cnt_sec <= w_dec_sec;
                        r_cnt_min <= w_dec_min;
                        r_cnt_hou <= w_dec_hou;
                    end
                    if (w_tick && w_dec_zero) begin
                        r_state   <= S_EXPIRED;
                        r_running <= 1'b0;
                        r_expired <= 1'b1;
                    end else if (w_e_pause) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (w_e_ack) begin
                        r_state   <= S_IDLE;
                        r_cnt_sec <= r_pre_sec;
                        r_cnt_min <= r_pre_min;
                        r_cnt_hou <= r_pre_hou;
                    end else if (w_e_start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_EXPIRED: begin
                    if (w_e_ack) begin
                        r_state   <= S_IDLE;
                        r_expired <= 1'b0;
                        r_cnt_sec <= r_pre_sec;
                        r_cnt_min <= r_pre_min;
                        r_cnt_hou <= r_pre_hou;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign running = r_running;
    assign expired = r_expired;

    function automatic logic [6:0] seg7(input logic [7:0] d);
        case (d)
            8'd0:    seg7 = 7'h40;
            8'd1:    seg7 = 7'h79;
            8'd2:    seg7 = 7'h24;
            8'd3:    seg7 = 7'h30;
            8'd4:    seg7 = 7'h19;
            8'd5:    seg7 = 7'h12;
            8'd6:    seg7 = 7'h02;
            8'd7:    seg7 = 7'h78;
            8'd8:    seg7 = 7'h00;
            8'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [7:0] w_unit [3];
    logic [6:0] w_hex  [6];

    assign w_unit[0] = r_cnt_sec;
    assign w_unit[1] = r_cnt_min;
    assign w_unit[2] = r_cnt_hou;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            logic [7:0] w_tens, w_ones;
            assign w_tens         = w_unit[gi] / 8'd10;
            assign w_ones         = w_unit[gi] - w_tens * 8'd10;
            assign w_hex[2*gi]    = seg7(w_ones);
            assign w_hex[2*gi+1]  = seg7(w_tens);
        end
    endgenerate

    assign HEX0 = w_hex[0];
    assign HEX1 = w_hex[1];
    assign HEX2 = w_hex[2];
    assign HEX3 = w_hex[3];
    assign HEX4 = w_hex[4];
    assign HEX5 = w_hex[5];

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a seconds-based reference model predicts every cycle,
// a separate monitor compares the DUT against the queued predictions.
module tb_countdown_timer;

    localparam int TD = 4;

    // Input bit order: {ack, pause, start, adj_hou, adj_min, adj_sec}
    localparam bit [5:0] AS = 6'b000001;
    localparam bit [5:0] AM = 6'b000010;
    localparam bit [5:0] AH = 6'b000100;
    localparam bit [5:0] ST = 6'b001000;
    localparam bit [5:0] PA = 6'b010000;
    localparam bit [5:0] AK = 6'b100000;
    localparam bit [5:0] NO = 6'b000000;

    logic       CLK = 1'b0;
    logic       clr_n = 1'b0;
    logic       adj_sec = 1'b0, adj_min = 1'b0, adj_hou = 1'b0;
    logic       start = 1'b0, pause = 1'b0, ack = 1'b0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic       running, expired;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .CLK(CLK), .clr_n(clr_n),
        .adj_sec(adj_sec), .adj_min(adj_min), .adj_hou(adj_hou),
        .start(start), .pause(pause), .ack(ack),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .running(running), .expired(expired)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [6:0] h5, h4, h3, h2, h1, h0;
        logic       run;
        logic       exp;
    } obs_t;

    obs_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [6:0] seg_tab [10];

    // Reference model: mode 0=idle 1=run 2=pause 3=expired; remaining time kept as plain seconds.
    int       m_mode, m_ps, m_pm, m_ph, m_rem, m_phase;
    bit [5:0] m_prev;

    function automatic int preset_total();
        return m_ph * 3600 + m_pm * 60 + m_ps;
    endfunction

    function automatic obs_t predict();
        obs_t o;
        int h, m, s;
        h = m_rem / 3600;
        m = (m_rem / 60) % 60;
        s = m_rem % 60;
        o.h0 = seg_tab[s % 10]; o.h1 = seg_tab[s / 10];
        o.h2 = seg_tab[m % 10]; o.h3 = seg_tab[m / 10];
        o.h4 = seg_tab[h % 10]; o.h5 = seg_tab[h / 10];
        o.run = (m_mode == 1);
        o.exp = (m_mode == 3);
        return o;
    endfunction

    task automatic model_step(input bit rn, input bit [5:0] ins);
        bit [5:0] e;
        bit tick;
        if (!rn) begin
            m_mode = 0; m_ps = 0; m_pm = 0; m_ph = 0;
            m_rem = 0; m_phase = 0; m_prev = '1;
        end else begin
            e = ins & ~m_prev;
            m_prev = ins;
            case (m_mode)
                0: begin
                    if (e[3] && preset_total() != 0) begin
                        m_mode = 1; m_phase = 0;
                    end else begin
                        if (e[0]) m_ps = (m_ps + 1) % 60;
                        if (e[1]) m_pm = (m_pm + 1) % 60;
                        if (e[2]) m_ph = (m_ph + 1) % 24;
                        m_rem = preset_total();
                    end
                end
                1: begin
                    tick = (m_phase == TD - 1);
                    m_phase = (m_phase + 1) % TD;
                    if (tick) m_rem = m_rem - 1;
                    if (m_rem == 0) m_mode = 3;
                    else if (e[4]) m_mode = 2;
                end
                2: begin
                    if (e[5]) begin m_mode = 0; m_rem = preset_total(); end
                    else if (e[3]) m_mode = 1;
                end
                default: begin
                    if (e[5]) begin m_mode = 0; m_rem = preset_total(); end
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the prediction for the next rising edge.
    task automatic step(input bit rn, input bit [5:0] ins);
        @(negedge CLK);
        clr_n   = rn;
        adj_sec = ins[0]; adj_min = ins[1]; adj_hou = ins[2];
        start   = ins[3]; pause   = ins[4]; ack     = ins[5];
        model_step(rn, ins);
        q_exp.push_back(predict());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, NO);
    endtask

    task automatic pulse(input bit [5:0] ins, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, ins);
            step(1'b1, NO);
        end
    endtask

    task automatic do_reset();
        step(1'b0, NO);
        step(1'b0, NO);
        step(1'b1, NO);
    endtask

    // Direct comparison of the display against fixed constants.
    task automatic check_hms(input string name, input int h, input int m, input int s);
        logic [41:0] got, want;
        got  = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
        want = {seg_tab[h / 10], seg_tab[h % 10], seg_tab[m / 10],
                seg_tab[m % 10], seg_tab[s / 10], seg_tab[s % 10]};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: display got %h required %h (%0d:%0d:%0d)", name, got, want, h, m, s);
        end
    endtask

    // Monitor: pops one prediction per rising edge and compares it with what the DUT presents.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge CLK);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                a = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, running, expired};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    if (n_fail <= 30)
                        $display("FAIL scoreboard @%0t: got %h required %h (run %b/%b exp %b/%b)",
                                 $time, a, e, a.run, e.run, a.exp, e.exp);
                end
            end
        end
    end

    initial begin
        int r;
        bit [5:0] ins;
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        model_step(1'b0, NO);

        // 1: preset 00:01:03, then adj edges while running must not touch the display
        do_reset();
        check_hms("reset_display", 0, 0, 0);
        pulse(AS, 3);
        pulse(AM, 1);
        check_hms("preset_00_01_03", 0, 1, 3);
        pulse(ST, 1);
        pulse(AS | AM | AH, 3);
        idle(3);

        // 2: two-second run to expiry, alarm held, ack reloads preset
        do_reset();
        pulse(AS, 2);
        pulse(ST, 1);
        idle(14);
        pulse(AK, 1);
        check_hms("ack_reload_00_00_02", 0, 0, 2);

        // 3: hour and minute borrows, preset wrap-around
        do_reset();
        pulse(AH, 1);
        step(1'b1, ST);
        idle(5);
        check_hms("borrow_00_59_59", 0, 59, 59);
        do_reset();
        pulse(AM, 1);
        step(1'b1, ST);
        idle(5);
        check_hms("borrow_00_00_59", 0, 0, 59);
        do_reset();
        pulse(AS, 60);
        pulse(AH, 24);
        check_hms("preset_wrap", 0, 0, 0);

        // 4: pause freezes count and prescaler; pause on a tick cycle
        do_reset();
        pulse(AS, 5);
        step(1'b1, ST);
        idle(5);
        step(1'b1, PA);
        idle(20);
        check_hms("paused_00_00_04", 0, 0, 4);
        step(1'b1, ST);
        step(1'b1, NO);
        step(1'b1, PA);
        idle(6);
        pulse(AK, 1);

        // 5: start+ack in pause, start on zero preset, start+adj in idle
        pulse(AS, 2);
        pulse(ST, 2);
        pulse(PA, 1);
        step(1'b1, ST | AK);
        idle(3);
        do_reset();
        pulse(ST, 2);
        pulse(AS, 1);
        step(1'b1, ST | AS);
        idle(10);
        pulse(AK, 1);
        check_hms("start_adj_preset_kept", 0, 0, 1);

        // 6: asynchronous reset mid-run, start held across reset release
        pulse(AS, 7);
        pulse(ST, 1);
        idle(5);
        step(1'b0, NO);
        #1;
        n_tests++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, running, expired} !==
            {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h %h %h %h %h %h run %b exp %b required all 40, 0, 0",
                     HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, running, expired);
        end
        step(1'b0, ST);
        step(1'b1, ST);
        step(1'b1, ST);
        idle(3);

        // Randomized traffic, occasionally asserting reset
        for (int c = 0; c < 2500; c++) begin
            ins = NO;
            if ($urandom_range(0, 3) == 0)   ins |= AS;
            if ($urandom_range(0, 39) == 0)  ins |= AM;
            if ($urandom_range(0, 79) == 0)  ins |= AH;
            if ($urandom_range(0, 9) == 0)   ins |= ST;
            if ($urandom_range(0, 29) == 0)  ins |= PA;
            if ($urandom_range(0, 24) == 0)  ins |= AK;
            r = $urandom_range(0, 599);
            step((r == 0) ? 1'b0 : 1'b1, ins);
        end

        idle(2);
        for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge CLK);
        #2;
        if (q_exp.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d predictions left, required 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
